intc: RTL and testbench



---
 rtl/intc.sv | 144 ++++++++++++++
 tb/tb_intc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/intc.sv
// intc: registered interrupt controller in front of the bexkat2 CPU.
// Captures the seven system interrupt sources (level or rising-edge), masks
// them, priority-encodes them into the CPU's 3-bit interrupt vector and exposes
// PENDING / MASK / EDGE / VECTOR registers through a small Wishbone slave.
module intc #(
  parameter int NSRC = 7
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic [NSRC-1:0] src_i,
  input  logic            int_en,
  output logic [2:0]      cpu_interrupt,
  input  logic [1:0]      adr_i,
  input  logic [31:0]     dat_i,
  output logic [31:0]     dat_o,
  input  logic            we_i,
  input  logic [3:0]      sel_i,
  input  logic            stb_i,
  input  logic            cyc_i,
  output logic            ack_o
);

  localparam logic [1:0] ADR_PENDING = 2'd0;
  localparam logic [1:0] ADR_MASK    = 2'd1;
  localparam logic [1:0] ADR_EDGE    = 2'd2;
  localparam logic [1:0] ADR_VECTOR  = 2'd3;

  // Source state and software-visible registers.
  logic [NSRC-1:0] prev;
  logic [NSRC-1:0] latch;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] edge_mode;

  // Combinational views derived from the registers above.
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] act;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] latch_next;
  logic [2:0]      vec_next;
  logic [31:0]     rd_data;

  // Bus decode.
  logic access;
  logic wr_en;
  logic wr_pending;
  logic wr_mask;
  logic wr_edge;

  // Upper data bits and byte lanes 3..1 carry nothing for this block.
  logic unused_bits;
  assign unused_bits = ^{dat_i[31:NSRC], sel_i[3:1]};

  // Fixed priority: mmu_fault first, then io 5..2, then io 1 and io 0 which
  // map to vectors 6 and 7 for compatibility with the old top-level encoder.
  function automatic logic [2:0] encode(input logic [NSRC-1:0] a);
    logic [2:0] v;
    v = 3'd0;
    if (a[6])      v = 3'd1;
    else if (a[5]) v = 3'd5;
    else if (a[4]) v = 3'd4;
    else if (a[3]) v = 3'd3;
    else if (a[2]) v = 3'd2;
    else if (a[1]) v = 3'd6;
    else if (a[0]) v = 3'd7;
    return v;
  endfunction

  // An access is accepted on the edge that raises ack; a held strobe
  // therefore produces one transfer every other cycle.
  assign access     = stb_i & cyc_i & ~ack_o;
  assign wr_en      = access & we_i & sel_i[0];
  assign wr_pending = wr_en & (adr_i == ADR_PENDING);
  assign wr_mask    = wr_en & (adr_i == ADR_MASK);
  assign wr_edge    = wr_en & (adr_i == ADR_EDGE);

  // Pending view, masking, edge detect and latch update (set beats clear).
  always_comb begin
    rise       = src_i & ~prev;
    clr        = wr_pending ? dat_i[NSRC-1:0] : '0;
    latch_next = (latch & ~clr) | rise;
    for (int i = 0; i < NSRC; i++) begin
      pending[i] = edge_mode[i] ? latch[i] : src_i[i];
    end
    act      = pending & mask;
    vec_next = int_en ? encode(act) : 3'd0;
  end

  // Read mux, sampled into dat_o when an access is accepted.
  always_comb begin
    rd_data = 32'd0;
    case (adr_i)
      ADR_PENDING: rd_data[NSRC-1:0] = pending;
      ADR_MASK:    rd_data[NSRC-1:0] = mask;
      ADR_EDGE:    rd_data[NSRC-1:0] = edge_mode;
      ADR_VECTOR:  rd_data[2:0]      = cpu_interrupt;
      default:     rd_data           = 32'd0;
    endcase
  end

  // Previous-sample register and edge latches; prev resets to 0 so a source
  // already high when reset releases is seen as a rising edge.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= '0;
      latch <= '0;
    end else begin
      prev  <= src_i;
      latch <= latch_next;
    end
  end

  // Software MASK and EDGE registers; writes commit on the ack edge.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mask      <= '1;
      edge_mode <= '0;
    end else begin
      if (wr_mask) mask      <= dat_i[NSRC-1:0];
      if (wr_edge) edge_mode <= dat_i[NSRC-1:0];
    end
  end

  // Wishbone acknowledge and registered read data (held until next access).
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_o <= 1'b0;
      dat_o <= 32'd0;
    end else begin
      ack_o <= access;
      if (access) dat_o <= rd_data;
    end
  end

  // Registered vector to the CPU, forced to 0 while interrupts are disabled.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cpu_interrupt <= 3'd0;
    end else begin
      cpu_interrupt <= vec_next;
    end
  end

endmodule

// File: tb/tb_intc.sv
// tb_intc: directed and randomized bench for intc with a behavioural model.
module tb_intc;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  src_i = 7'h00;
  logic        int_en = 1'b0;
  logic [2:0]  cpu_interrupt;
  logic [1:0]  adr_i = 2'd0;
  logic [31:0] dat_i = 32'd0;
  logic [31:0] dat_o;
  logic        we_i = 1'b0;
  logic [3:0]  sel_i = 4'd0;
  logic        stb_i = 1'b0;
  logic        cyc_i = 1'b0;
  logic        ack_o;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  intc #(.NSRC(7)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .src_i(src_i), .int_en(int_en),
    .cpu_interrupt(cpu_interrupt), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Vector assigned to each source bit, and the order bits are considered in.
  int vec_of_bit[7] = '{7, 6, 2, 3, 4, 5, 1};
  int order[7]      = '{6, 5, 4, 3, 2, 1, 0};

  function automatic int prio(input logic [6:0] a);
    for (int k = 0; k < 7; k++) begin
      if (a[order[k]]) return vec_of_bit[order[k]];
    end
    return 0;
  endfunction

  logic [6:0]  m_prev, m_latch, m_mask, m_edge;
  int          m_vec;
  bit          m_ack;
  logic [31:0] m_dat;

  always @(posedge clk_i or negedge rst_n) begin
    logic [6:0]  pend;
    logic [31:0] rd;
    bit acc, wr;
    if (!rst_n) begin
      m_prev = 0; m_latch = 0; m_mask = 7'h7F; m_edge = 0;
      m_vec = 0; m_ack = 0; m_dat = 0;
    end else begin
      for (int i = 0; i < 7; i++) pend[i] = m_edge[i] ? m_latch[i] : src_i[i];
      acc = stb_i && cyc_i && !m_ack;
      wr  = acc && we_i && sel_i[0];
      if (acc) begin
        case (adr_i)
          2'd0: rd = 32'(pend);
          2'd1: rd = 32'(m_mask);
          2'd2: rd = 32'(m_edge);
          default: rd = 32'(m_vec);
        endcase
        m_dat = rd;
      end
      m_vec = int_en ? prio(pend & m_mask) : 0;
      for (int i = 0; i < 7; i++) begin
        if (src_i[i] && !m_prev[i]) m_latch[i] = 1'b1;
        else if (wr && adr_i == 2'd0 && dat_i[i]) m_latch[i] = 1'b0;
      end
      if (wr && adr_i == 2'd1) m_mask = dat_i[6:0];
      if (wr && adr_i == 2'd2) m_edge = dat_i[6:0];
      m_ack  = acc;
      m_prev = src_i;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(posedge clk_i) begin
    #1;
    if (chk_on) begin
      check("model_vec", 32'(cpu_interrupt), 32'(m_vec));
      check("model_ack", 32'(ack_o), 32'(m_ack));
      check("model_dat", dat_o, m_dat);
    end
  end

  // ---------------- bus helpers (called at a negedge) ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    adr_i = a; dat_i = d; sel_i = s; we_i = 1'b1; stb_i = 1'b1; cyc_i = 1'b1;
    @(negedge clk_i);
    check("wr_ack", 32'(ack_o), 32'd1);
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    adr_i = a; sel_i = 4'hF; we_i = 1'b0; stb_i = 1'b1; cyc_i = 1'b1;
    check("rd_ack_pre", 32'(ack_o), 32'd0);
    @(negedge clk_i);
    check("rd_ack", 32'(ack_o), 32'd1);
    d = dat_o;
    stb_i = 1'b0; cyc_i = 1'b0;
    @(negedge clk_i);
    check("rd_ack_post", 32'(ack_o), 32'd0);
  endtask

  initial begin
    logic [31:0] rdv;

    // Pin the model's priority table with hand-derived values.
    check("prio_11", 32'(prio(7'b0000011)), 32'd6);
    check("prio_01", 32'(prio(7'b0000001)), 32'd7);
    check("prio_24", 32'(prio(7'b0100100)), 32'd5);
    check("prio_7f", 32'(prio(7'h7F)), 32'd1);
    check("prio_00", 32'(prio(7'h00)), 32'd0);

    // Reset defaults with all sources asserted.
    rst_n = 1'b0; src_i = 7'h7F; int_en = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_vec", 32'(cpu_interrupt), 32'd0);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_dat", dat_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk_i);
    chk_on = 1'b1;
    check("post_rst_vec", 32'(cpu_interrupt), 32'd1);

    // Priority in level mode.
    src_i = 7'b0000011; @(negedge clk_i);
    check("prio_lvl_6", 32'(cpu_interrupt), 32'd6);
    src_i = 7'b0000001; @(negedge clk_i);
    check("prio_lvl_7", 32'(cpu_interrupt), 32'd7);
    src_i = 7'b0100100; @(negedge clk_i);
    check("prio_lvl_5", 32'(cpu_interrupt), 32'd5);

    // Masking.
    src_i = 7'h40;
    bus_write(2'd1, 32'h3F, 4'h1);
    @(negedge clk_i);
    check("mask_vec", 32'(cpu_interrupt), 32'd0);
    bus_read(2'd1, rdv);
    check("mask_rd", rdv, 32'h3F);
    bus_write(2'd1, 32'h7F, 4'h1);

    // Edge latch and W1C (latches were all set when reset released).
    src_i = 7'h00;
    bus_write(2'd0, 32'h7F, 4'h1);
    bus_write(2'd2, 32'h04, 4'h1);
    src_i = 7'h04; @(negedge clk_i);
    src_i = 7'h00; @(negedge clk_i);
    check("edge_vec", 32'(cpu_interrupt), 32'd2);
    repeat (3) @(negedge clk_i);
    check("edge_hold", 32'(cpu_interrupt), 32'd2);
    bus_read(2'd0, rdv);
    check("pend_rd", rdv, 32'h4);
    bus_write(2'd0, 32'h4, 4'h1);
    check("w1c_vec", 32'(cpu_interrupt), 32'd0);
    // Rising edge coincident with the clearing write: set wins.
    src_i = 7'h04;
    adr_i = 2'd0; dat_i = 32'h4; sel_i = 4'h1; we_i = 1'b1; stb_i = 1'b1; cyc_i = 1'b1;
    @(negedge clk_i);
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0; src_i = 7'h00;
    @(negedge clk_i);
    check("set_wins", 32'(cpu_interrupt), 32'd2);
    bus_write(2'd0, 32'h4, 4'h1);
    bus_write(2'd2, 32'h0, 4'h1);

    // Byte select and global enable.
    bus_write(2'd1, 32'h0, 4'b1110);
    bus_read(2'd1, rdv);
    check("sel_mask", rdv, 32'h7F);
    int_en = 1'b0; src_i = 7'h08;
    repeat (2) @(negedge clk_i);
    check("inten_off", 32'(cpu_interrupt), 32'd0);
    int_en = 1'b1; @(negedge clk_i);
    check("inten_on", 32'(cpu_interrupt), 32'd3);
    bus_read(2'd3, rdv);
    check("vec_rd", rdv, 32'd3);

    // Held strobe: ack every other cycle.
    adr_i = 2'd1; we_i = 1'b0; stb_i = 1'b1; cyc_i = 1'b1;
    check("held_ack0", 32'(ack_o), 32'd0); @(negedge clk_i);
    check("held_ack1", 32'(ack_o), 32'd1); @(negedge clk_i);
    check("held_ack2", 32'(ack_o), 32'd0); @(negedge clk_i);
    check("held_ack3", 32'(ack_o), 32'd1);
    stb_i = 1'b0; cyc_i = 1'b0; @(negedge clk_i);

    // Reset in the middle of a write aborts it.
    src_i = 7'h00;
    adr_i = 2'd1; dat_i = 32'h0; sel_i = 4'h1; we_i = 1'b1; stb_i = 1'b1; cyc_i = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("abort_ack", 32'(ack_o), 32'd0);
    @(negedge clk_i);
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    check("abort_ack_hold", 32'(ack_o), 32'd0);
    rst_n = 1'b1; @(negedge clk_i);
    bus_read(2'd1, rdv);
    check("abort_mask", rdv, 32'h7F);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_i);
      if ($urandom_range(0, 3) == 0) src_i[$urandom_range(0, 6)] ^= 1'b1;
      int_en = ($urandom_range(0, 7) != 0);
      stb_i  = ($urandom_range(0, 2) == 0);
      cyc_i  = ($urandom_range(0, 4) != 0);
      we_i   = $urandom_range(0, 1);
      adr_i  = 2'($urandom_range(0, 3));
      dat_i  = $urandom;
      sel_i  = 4'($urandom_range(0, 15));
    end
    stb_i = 1'b0; cyc_i = 1'b0;
    repeat (3) @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
